gpio_port: RTL and testbench
============================

GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the number of GPIO pins (1..16).
REQ-002 SHALL have parameter OUT_RESET, default 0, giving the gpio_out value applied at reset (WIDTH bits).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port GPIO_W, input, 1 bit: write strobe from the GPIO address decoder (MemW qualified by address 0xABCD).
REQ-006 SHALL have port WriteData, input, 32 bits: store data; [31:30] is the command and [WIDTH-1:0] is the operand.
REQ-007 SHALL have port gpio_in, input, WIDTH bits: asynchronous external input pins.
REQ-008 SHALL have port gpio_out, output, WIDTH bits: registered output pin values.
REQ-009 SHALL have port ReadData, output, 32 bits: {edge_flags zero-extended to 16 bits, gpio_in_sync zero-extended to 16 bits}; combinational from registers only.
REQ-010 SHALL have port irq, output, 1 bit: OR-reduction of edge_flags; registered state only, with no combinational path from any input.

Function
REQ-011 SHALL act on WriteData only in cycles with GPIO_W=1; GPIO_W=0 leaves gpio_out and edge_flags unaffected by WriteData.
REQ-012 SHALL execute the write command on the clk edge where GPIO_W=1 as follows:
- cmd 00: gpio_out <= operand.
- cmd 01: gpio_out <= gpio_out | operand.
- cmd 10: gpio_out <= gpio_out & ~operand.
- cmd 11: clear edge_flags bits where operand=1; gpio_out unchanged.
REQ-013 SHALL make each write visible on gpio_out one edge after the strobe (latency 1); back-to-back strobes on consecutive cycles SHALL each take effect in order.
REQ-014 SHALL ignore WriteData[29:WIDTH].
REQ-015 SHALL synchronise gpio_in through a chain s1 <= gpio_in, s2 <= s1, s3 <= s2, with gpio_in_sync = s2.
REQ-016 SHALL therefore show a pin level stable before edge k on gpio_in_sync after edge k+1.
REQ-017 SHALL define rise[i] = s2[i] & ~s3[i], and SHALL set edge_flags[i] on the edge after rise[i]=1 (edge k+2 for a pin rising before edge k).
REQ-018 SHALL keep edge_flags sticky: a set bit remains 1 until cleared by cmd 11 or by reset.
REQ-019 SHALL give set priority when rise[i] and a cmd-11 clear of bit i occur in the same cycle: edge_flags[i] SHALL be 1 afterwards.
REQ-020 SHALL produce no edge flags on falling edges.
REQ-021 SHALL include a 2-bit arm counter that is cleared by reset and increments each cycle, saturating at 3.
REQ-022 SHALL suppress edge_flags setting while the arm counter is below 3, so that pins already high at reset release produce no flag.
REQ-023 SHALL leave write commands unaffected by the arm state.

Reset
REQ-024 SHALL, while reset=1 and independent of clk, drive gpio_out=OUT_RESET, s1=s2=s3=0, edge_flags=0, arm counter=0, irq=0, and ReadData=0.
REQ-025 SHALL, on reset assertion mid-operation (including a cycle with GPIO_W=1), discard the pending write and leave all state at its reset values.

Verification
REQ-026 SHALL be verified by: reset, GPIO_W=1, WriteData=0x0000_00A5 for one cycle -> gpio_out=0x00A5 one edge later, edge_flags=0.
REQ-027 SHALL be verified by: gpio_out=0x00A5, then cmd01 with 0x0F00, then cmd10 with 0x0005 on consecutive cycles -> gpio_out=0x0FA5, then 0x0FA0.
REQ-028 SHALL be verified by: gpio_in[3] raised before edge k -> ReadData[3]=1 after edge k+1, ReadData[19]=1 and irq=1 after edge k+2.
REQ-029 SHALL be verified by: edge_flags=0x0008 with cmd11 and operand 0x0008 -> edge_flags=0 and irq=0; repeating the clear in the same cycle as a new rise on pin 3 -> edge_flags[3]=1.
REQ-030 SHALL be verified by: gpio_in=0xFFFF held through reset release -> edge_flags remains 0 for 10 cycles and gpio_in_sync=0xFFFF.
REQ-031 SHALL be verified by: reset asserted asynchronously between edges while GPIO_W=1 with cmd00 and operand 0x1234 -> gpio_out=OUT_RESET immediately and after release.

Source files
------------

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: registered outputs with set/clear/load commands, a two-flop
// input synchroniser, and sticky rising-edge flags that drive a registered interrupt.
module gpio_port #(
    parameter int unsigned           WIDTH     = 16,
    parameter logic [WIDTH-1:0]      OUT_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             GPIO_W,
    input  logic [31:0]      WriteData,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [31:0]      ReadData,
    output logic             irq
);

    typedef enum logic [1:0] {
        CmdLoad  = 2'b00,
        CmdSet   = 2'b01,
        CmdClr   = 2'b10,
        CmdFlags = 2'b11
    } cmd_e;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] s3_q, s3_d;
    logic [WIDTH-1:0] flags_q, flags_d;
    logic [1:0]       arm_q, arm_d;

    cmd_e             cmd;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] rise;
    logic             armed;
    logic [15:0]      flags_ext;
    logic [15:0]      sync_ext;
    logic             unused_write_bits;

    assign cmd     = cmd_e'(WriteData[31:30]);
    assign operand = WriteData[WIDTH-1:0];
    assign unused_write_bits = ^WriteData[29:WIDTH];

    assign rise  = s2_q & ~s3_q;
    assign armed = (arm_q == 2'd3);

    always_comb begin
        out_d   = out_q;
        flags_d = flags_q;
        if (GPIO_W) begin
            unique case (cmd)
                CmdLoad:  out_d = operand;
                CmdSet:   out_d = out_q | operand;
                CmdClr:   out_d = out_q & ~operand;
                CmdFlags: flags_d = flags_q & ~operand;
                default:  out_d = out_q;
            endcase
        end
        // Setting after clearing gives a coincident rise priority over a clear.
        if (armed) begin
            flags_d = flags_d | rise;
        end
    end

    always_comb begin
        s1_d  = gpio_in;
        s2_d  = s1_q;
        s3_d  = s2_q;
        arm_d = armed ? arm_q : arm_q + 2'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= OUT_RESET;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            flags_q <= '0;
            arm_q   <= 2'd0;
        end else begin
            out_q   <= out_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            flags_q <= flags_d;
            arm_q   <= arm_d;
        end
    end

    always_comb begin
        flags_ext              = '0;
        sync_ext               = '0;
        flags_ext[WIDTH-1:0]   = flags_q;
        sync_ext[WIDTH-1:0]    = s2_q;
    end

    assign gpio_out = out_q;
    assign ReadData = {flags_ext, sync_ext};
    assign irq      = |flags_q;

endmodule

// File: tb/tb_gpio_port.sv
// Randomized bench for gpio_port, checked against a sample-history model of the port.
module tb_gpio_port;

    localparam int unsigned W      = 16;
    localparam logic [15:0] OutRst = 16'hC003;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        GPIO_W = 1'b0;
    logic [31:0] WriteData = '0;
    logic [15:0] gpio_in = '0;
    logic [15:0] gpio_out;
    logic [31:0] ReadData;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;

    // Model: output register, flags and the history of pin samples taken at each edge
    logic [15:0] m_out;
    logic [15:0] m_flags;
    logic [15:0] samp[$];

    gpio_port #(.WIDTH(W), .OUT_RESET(OutRst)) dut (
        .clk       (clk),
        .reset     (reset),
        .GPIO_W    (GPIO_W),
        .WriteData (WriteData),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .ReadData  (ReadData),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] samp_at(int k);
        if (k < 1 || k > samp.size()) return 16'h0;
        return samp[k-1];
    endfunction

    function automatic logic [31:0] exp_rd();
        return {m_flags, samp_at(samp.size() - 1)};
    endfunction

    task automatic model_reset();
        m_out   = OutRst;
        m_flags = '0;
        samp.delete();
    endtask

    // Advance the model for the coming edge, then wait for it and settle.
    task automatic tick();
        int          n;
        logic [15:0] op;
        logic [15:0] nflags;
        if (!reset) begin
            n      = samp.size() + 1;
            op     = WriteData[15:0];
            nflags = m_flags;
            if (GPIO_W) begin
                case (WriteData[31:30])
                    2'b00: m_out = op;
                    2'b01: m_out = m_out | op;
                    2'b10: m_out = m_out & ~op;
                    default: nflags = nflags & ~op;
                endcase
            end
            if (n >= 4) nflags = nflags | (samp_at(n - 2) & ~samp_at(n - 3));
            m_flags = nflags;
            samp.push_back(gpio_in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        tick();
        tick();
        vectors++;
        if (gpio_out !== OutRst) begin
            miscompares++;
            $display("FAIL reset_out: got %h expected %h", gpio_out, OutRst);
        end
        vectors++;
        if (ReadData !== 32'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rd: got rd=%h irq=%b expected rd=0 irq=0", ReadData, irq);
        end
        reset = 1'b0;
    endtask

    task automatic test_write();
        GPIO_W = 1'b1;
        WriteData = 32'h0000_00A5;
        tick();
        GPIO_W = 1'b0;
        vectors++;
        if (gpio_out !== 16'h00A5 || gpio_out !== m_out) begin
            miscompares++;
            $display("FAIL write_load: got %h expected %h", gpio_out, 16'h00A5);
        end
        vectors++;
        if (ReadData[31:16] !== 16'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL write_flags: got %h irq=%b expected 0", ReadData[31:16], irq);
        end
    endtask

    task automatic test_back_to_back();
        GPIO_W = 1'b1;
        WriteData = 32'h4000_0F00;
        tick();
        vectors++;
        if (gpio_out !== 16'h0FA5) begin
            miscompares++;
            $display("FAIL b2b_set: got %h expected %h", gpio_out, 16'h0FA5);
        end
        WriteData = 32'h8000_0005;
        tick();
        GPIO_W = 1'b0;
        WriteData = 32'h0000_FFFF;
        vectors++;
        if (gpio_out !== 16'h0FA0) begin
            miscompares++;
            $display("FAIL b2b_clr: got %h expected %h", gpio_out, 16'h0FA0);
        end
        tick();
        vectors++;
        if (gpio_out !== 16'h0FA0) begin
            miscompares++;
            $display("FAIL idle_hold: got %h expected %h", gpio_out, 16'h0FA0);
        end
    endtask

    task automatic test_edge();
        gpio_in = 16'h0;
        repeat (3) tick();
        gpio_in[3] = 1'b1;
        tick();
        vectors++;
        if (ReadData !== exp_rd() || ReadData[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_k: got %h expected %h", ReadData, exp_rd());
        end
        tick();
        vectors++;
        if (ReadData[3] !== 1'b1 || ReadData[19] !== 1'b0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_k1: got rd=%h irq=%b expected rd[3]=1 rd[19]=0 irq=0",
                     ReadData, irq);
        end
        tick();
        vectors++;
        if (ReadData[19] !== 1'b1 || irq !== 1'b1 || ReadData !== exp_rd()) begin
            miscompares++;
            $display("FAIL edge_k2: got rd=%h irq=%b expected rd=%h irq=1",
                     ReadData, irq, exp_rd());
        end
    endtask

    task automatic test_clear_priority();
        GPIO_W = 1'b1;
        WriteData = 32'hC000_0008;
        tick();
        GPIO_W = 1'b0;
        vectors++;
        if (ReadData[31:16] !== 16'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL flag_clear: got %h irq=%b expected 0", ReadData[31:16], irq);
        end
        gpio_in[3] = 1'b0;
        repeat (3) tick();
        gpio_in[3] = 1'b1;
        tick();
        tick();
        GPIO_W = 1'b1;
        WriteData = 32'hC000_0008;
        tick();
        GPIO_W = 1'b0;
        vectors++;
        if (ReadData[19] !== 1'b1 || irq !== 1'b1 || ReadData !== exp_rd()) begin
            miscompares++;
            $display("FAIL set_priority: got rd=%h irq=%b expected rd=%h", ReadData, irq,
                     exp_rd());
        end
    endtask

    task automatic test_arm();
        gpio_in = 16'hFFFF;
        #2;
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (ReadData[31:16] !== 16'h0 || irq !== 1'b0 || ReadData !== exp_rd()) begin
                miscompares++;
                $display("FAIL arm_cycle%0d: got rd=%h irq=%b expected rd=%h", i, ReadData,
                         irq, exp_rd());
            end
        end
        vectors++;
        if (ReadData[15:0] !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL arm_sync: got %h expected ffff", ReadData[15:0]);
        end
    endtask

    task automatic test_async_reset();
        GPIO_W = 1'b1;
        WriteData = 32'h0000_1234;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (gpio_out !== OutRst || ReadData !== 32'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst: got out=%h rd=%h irq=%b expected out=%h rd=0 irq=0",
                     gpio_out, ReadData, irq, OutRst);
        end
        tick();
        reset = 1'b0;
        GPIO_W = 1'b0;
        tick();
        vectors++;
        if (gpio_out !== OutRst) begin
            miscompares++;
            $display("FAIL async_rst_rel: got %h expected %h", gpio_out, OutRst);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            GPIO_W    = ($urandom_range(0, 2) != 0);
            WriteData = $urandom;
            gpio_in   = gpio_in ^ 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 63) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
            vectors++;
            if (gpio_out !== m_out || ReadData !== exp_rd() || irq !== (|m_flags)) begin
                miscompares++;
                $display("FAIL random%0d: got out=%h rd=%h irq=%b expected out=%h rd=%h irq=%b",
                         i, gpio_out, ReadData, irq, m_out, exp_rd(), |m_flags);
            end
        end
        GPIO_W = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_edge();
        test_clear_priority();
        test_arm();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
